// File: rtl/tt_pkg.sv
// Shared types and constants for the runtime-loadable truth-table engine.
// Holds the engine state encoding, legal parameter ranges and depth helper.
package tt_pkg;

    typedef enum logic [1:0] {
        TT_EMPTY   = 2'd0,
        TT_LOADING = 2'd1,
        TT_RUN     = 2'd2
    } tt_state_e;

    localparam int N_IN_MIN  = 1;
    localparam int N_IN_MAX  = 8;
    localparam int N_OUT_MIN = 1;
    localparam int N_OUT_MAX = 32;

    function automatic int tt_depth(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic bit tt_params_legal(input int n_in, input int n_out);
        return (n_in >= N_IN_MIN) && (n_in <= N_IN_MAX) &&
               (n_out >= N_OUT_MIN) && (n_out <= N_OUT_MAX);
    endfunction

endpackage

// File: rtl/tt_table_ram.sv
// 2^N_IN x N_OUT register array: one synchronous write port, one
// combinational read port, cleared to zero by the asynchronous reset.
module tt_table_ram
    import tt_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [N_IN-1:0]  waddr,
    input  logic [N_OUT-1:0] wdata,
    input  logic [N_IN-1:0]  raddr,
    output logic [N_OUT-1:0] rdata
);

    localparam int DEPTH = tt_depth(N_IN);

    logic [N_OUT-1:0] mem [DEPTH];

    // NOTE: the array is reset on purpose: a partial table must never survive
    // a reset, so this stays flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/truth_table_engine.sv
// Runtime-loadable truth table: serial config load, then table lookups
// through a valid/ready pipeline with one registered output stage.
module truth_table_engine
    import tt_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [N_OUT-1:0] cfg_data,
    output logic             cfg_ready,
    output logic             table_ok,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_vec,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N_OUT-1:0] out_word,
    input  logic             out_ready
);

    localparam int             DEPTH     = tt_depth(N_IN);
    localparam bit             CFG_LEGAL = tt_params_legal(N_IN, N_OUT);
    localparam logic [N_IN:0]  IDX_LAST  = (N_IN + 1)'(DEPTH - 1);
    localparam logic [N_IN:0]  IDX_ONE   = (N_IN + 1)'(1);

    tt_state_e        state_q, state_d;
    logic [N_IN:0]    idx_q, idx_d;
    logic             mem_we;
    logic [N_OUT-1:0] rd_word;
    logic             in_accept;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TT_EMPTY;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mem_we  = 1'b0;
        case (state_q)
            TT_EMPTY, TT_RUN: begin
                if (cfg_start) begin
                    state_d = TT_LOADING;
                    idx_d   = '0;
                end
            end
            TT_LOADING: begin
                // A restart wins over a word offered in the same cycle.
                if (cfg_start) begin
                    idx_d = '0;
                end else if (cfg_valid) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        state_d = TT_RUN;
                    end
                end
            end
            default: state_d = TT_EMPTY;
        endcase
    end

    assign cfg_ready = (state_q == TT_LOADING);
    assign table_ok  = CFG_LEGAL && (state_q == TT_RUN);
    assign in_ready  = (state_q == TT_RUN) && (!out_valid || out_ready);
    assign in_accept = in_valid && in_ready;

    tt_table_ram #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (idx_q[N_IN-1:0]),
        .wdata (cfg_data),
        .raddr (in_vec),
        .rdata (rd_word)
    );

    // A pending word is held across a reload until downstream takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_word  <= '0;
        end else if (in_accept) begin
            out_valid <= 1'b1;
            out_word  <= rd_word;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_truth_table_engine.sv
// Self-checking bench for truth_table_engine (defaults N_IN=3, N_OUT=4):
// directed scenarios plus randomized traffic against a queue-based model.
module tb_truth_table_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start, cfg_valid;
    logic [3:0] cfg_data;
    logic       cfg_ready, table_ok;
    logic       in_valid;
    logic [2:0] in_vec;
    logic       in_ready, out_valid;
    logic [3:0] out_word;
    logic       out_ready;

    int tests = 0;
    int fails = 0;

    logic [3:0] model_tab [8];
    logic [3:0] load_buf  [8];
    logic [3:0] a_tab     [8];

    truth_table_engine #(.N_IN(3), .N_OUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .table_ok  (table_ok),
        .in_valid  (in_valid),
        .in_vec    (in_vec),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cfg_start cycle also offers a junk word that must be ignored/discarded.
    task automatic load_words(input int n);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 4'hE;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = load_buf[i];
            #1;
            tests++;
            if (cfg_ready !== 1'b1) begin
                fails++;
                $display("FAIL load_cfg_ready word %0d: got %b want 1", i, cfg_ready);
            end
            tick();
            model_tab[i] = load_buf[i];
        end
        cfg_valid = 1'b0;
    endtask

    task automatic do_query(input logic [2:0] v, input logic [3:0] exp, input string name);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = v;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s in_ready: got %b want 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_word !== exp) begin
            fails++;
            $display("FAIL %s: got valid=%b word=%b want valid=1 word=%b", name, out_valid, out_word, exp);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_vec   = 3'($urandom);
        #1;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || table_ok !== 1'b0 ||
            cfg_ready !== 1'b0 || out_word !== 4'h0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b table_ok=%b cfg_ready=%b out_word=%b want all 0",
                     in_ready, out_valid, table_ok, cfg_ready, out_word);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_query_ignored: out_valid=%b want 0", out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic load_a_table();
        for (int i = 0; i < 8; i++) load_buf[i] = a_tab[i];
        load_words(7);
        tests++;
        if (table_ok !== 1'b0) begin
            fails++;
            $display("FAIL load_a_early_ok: table_ok=%b want 0 after 7 words", table_ok);
        end
        cfg_valid = 1'b1;
        cfg_data  = load_buf[7];
        tick();
        cfg_valid = 1'b0;
        model_tab[7] = load_buf[7];
        tests++;
        if (table_ok !== 1'b1 || cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL load_a_done: table_ok=%b cfg_ready=%b want 1/0", table_ok, cfg_ready);
        end
    endtask

    task automatic test_load_a();
        load_a_table();
        do_query(3'b011, 4'b0110, "query_011");
        do_query(3'b100, 4'b1100, "query_100");
    endtask

    task automatic test_back_to_back();
        // A stray config word in RUN must not touch the table.
        cfg_valid = 1'b1;
        cfg_data  = 4'hF;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int v = 0; v < 8; v++) begin
            in_valid = 1'b1;
            in_vec   = 3'(v);
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_in_ready vec %0d: got %b want 1", v, in_ready);
            end
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_word !== model_tab[v]) begin
                fails++;
                $display("FAIL b2b vec %0d: got valid=%b word=%b want valid=1 word=%b", v, out_valid, out_word, model_tab[v]);
            end
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 3'b001;
        tick();
        in_vec = 3'b100;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_word !== 4'b1001 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: valid=%b word=%b in_ready=%b want 1/1001/0", c, out_valid, out_word, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_in_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_word !== 4'b1100) begin
            fails++;
            $display("FAIL bp_replace: valid=%b word=%b want 1/1100", out_valid, out_word);
        end
        tick();
    endtask

    task automatic test_reload();
        logic [3:0] pend;
        pend      = model_tab[3];
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 3'b011;
        tick();
        in_valid  = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_word !== pend || in_ready !== 1'b0 ||
            table_ok !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL reload_pending: valid=%b word=%b in_ready=%b table_ok=%b cfg_ready=%b want 1/%b/0/0/1",
                     out_valid, out_word, in_ready, table_ok, cfg_ready, pend);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reload_drain: out_valid=%b want 0", out_valid);
        end
        for (int i = 0; i < 8; i++) load_buf[i] = 4'hF;
        load_words(8);
        tests++;
        if (table_ok !== 1'b1) begin
            fails++;
            $display("FAIL reload_ones_ok: table_ok=%b want 1", table_ok);
        end
        do_query(3'b000, 4'b1111, "query_ones");
        for (int i = 0; i < 8; i++) load_buf[i] = 4'(i + 1);
        load_words(3);
        for (int i = 0; i < 8; i++) load_buf[i] = 4'((i * 3 + 5) % 16);
        load_words(8);
        for (int v = 0; v < 8; v++) begin
            do_query(3'(v), 4'((v * 3 + 5) % 16), "query_restart");
        end
        tick();
    endtask

    task automatic test_async_rst();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 3'b010;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) load_buf[i] = a_tab[i];
        load_words(5);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_word !== 4'h0 || cfg_ready !== 1'b0 ||
            table_ok !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: valid=%b word=%b cfg_ready=%b table_ok=%b in_ready=%b want all 0",
                     out_valid, out_word, cfg_ready, table_ok, in_ready);
        end
        for (int i = 0; i < 8; i++) model_tab[i] = 4'h0;
        tick();
        rst = 1'b0;
        tick();
        load_a_table();
        do_query(3'b011, 4'b0110, "rst_query_011");
        do_query(3'b100, 4'b1100, "rst_query_100");
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] exp_q [$];
        logic       exp_rdy;
        for (int i = 0; i < 8; i++) load_buf[i] = 4'($urandom);
        load_words(8);
        for (int c = 0; c < 200; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_vec    = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (exp_q.size() == 0) || out_ready;
            tests++;
            if (in_ready !== exp_rdy) begin
                fails++;
                $display("FAIL rand_in_ready cycle %0d: got %b want %b", c, in_ready, exp_rdy);
            end
            tests++;
            if (out_valid !== (exp_q.size() != 0)) begin
                fails++;
                $display("FAIL rand_out_valid cycle %0d: got %b want %b", c, out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                tests++;
                if (out_word !== exp_q[0]) begin
                    fails++;
                    $display("FAIL rand_out_word cycle %0d: got %b want %b", c, out_word, exp_q[0]);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && exp_rdy) exp_q.push_back(model_tab[in_vec]);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        a_tab[0] = 4'b0000; a_tab[1] = 4'b1001; a_tab[2] = 4'b0000; a_tab[3] = 4'b0110;
        a_tab[4] = 4'b1100; a_tab[5] = 4'b1001; a_tab[6] = 4'b1100; a_tab[7] = 4'b0110;
        for (int i = 0; i < 8; i++) model_tab[i] = 4'h0;
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 4'h0;
        in_valid  = 1'b0;
        in_vec    = 3'b000;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_load_a();
        test_back_to_back();
        test_backpressure();
        test_reload();
        test_async_rst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_engine.md
# truth_table_engine

Parametrised, clocked successor to the fixed combinational truth-table blocks used as synthesis targets. It holds a runtime-loadable truth table of 2^N_IN entries, each N_OUT bits wide. The table is filled over a serial config handshake. Input vectors are then evaluated through a valid/ready pipeline with one registered output stage. It sits between stimulus generators and netlist-equivalence checkers, so one block replaces any hard-coded N-input/M-output case table.

## Interface
- N_IN, default 3: number of logic inputs; table depth is 2^N_IN (legal range 1..8).
- N_OUT, default 4: number of logic outputs; table word width (legal range 1..32).
- clk  input  1: sole clock; all state changes on its rising edge.
- rst  input  1: asynchronous, active-high reset.
- cfg_start  input  1: one-cycle pulse that begins a table load.
- cfg_valid  input  1: cfg_data holds the next table word.
- cfg_data  input  N_OUT: table word; word k is the output for input vector k.
- cfg_ready  output  1: the engine accepts a config word this cycle.
- table_ok  output  1: a complete table is loaded.
- in_valid  input  1: in_vec is valid.
- in_vec  input  N_IN: input vector; bit N_IN-1 is the first/MSB input, matching {in1,in2,...} ordering.
- in_ready  output  1: the engine accepts in_vec this cycle.
- out_valid  output  1: out_word is valid.
- out_word  output  N_OUT: evaluated outputs; bit N_OUT-1 is out1.
- out_ready  input  1: downstream accepts out_word.

## Operation
- State machine: EMPTY -> LOADING -> RUN; RUN -> LOADING on cfg_start.
  - EMPTY: reset state. cfg_ready=0, in_ready=0, table_ok=0.
  - LOADING: cfg_ready=1. A word transfers when cfg_valid&cfg_ready, is written at load index idx, and increments idx. The transfer at idx=2^N_IN-1 moves the state to RUN and sets table_ok=1.
  - RUN: in_ready = !out_valid | out_ready. When in_valid&in_ready, the engine registers out_word=table[in_vec] and sets out_valid=1.
- cfg_start in EMPTY or RUN: enter LOADING, idx=0, table_ok=0. Table contents are not cleared; each word is overwritten as it loads.
- cfg_start while in LOADING restarts the load: idx=0 and a concurrent cfg_valid word is discarded.
- cfg_valid outside LOADING is ignored; in_valid outside RUN is ignored (in_ready=0).
- Pending output on reload: out_valid/out_word hold until out_ready. No new query is accepted until the state returns to RUN.
- Output register: out_valid clears on out_ready & !(in_valid&in_ready). Simultaneous drain and accept replaces the word with no bubble.
- out_word and out_valid are stable while out_valid & !out_ready.
- idx counter is N_IN+1 bits wide. Depth 2^N_IN never wraps within a load; the final write ends the load.

## Timing
- Reset values: state EMPTY, idx 0, table all zeros, cfg_ready 0, table_ok 0, in_ready 0, out_valid 0, out_word 0.
- Reset asserted mid-load or mid-query returns immediately to the above values; the partial table is discarded (zeroed).
- Query latency: 1 cycle. An input accepted at edge t gives out_valid=1 and out_word after edge t.
- Throughput: 1 query/cycle while out_ready=1.
- Load time: 2^N_IN accepted words. table_ok rises after the edge accepting the last word, and in_ready may be 1 in the next cycle.
- cfg_ready is registered from state only; in_ready is combinational from state, out_valid and out_ready.
- Table reads use the value written in a previous cycle. Reads and writes are never concurrent, because states are exclusive.

## Structure
- Shared package tt_pkg holds:
  - the state enum (TT_EMPTY, TT_LOADING, TT_RUN);
  - the legal-range constants for N_IN and N_OUT;
  - a function giving depth = 1<<N_IN.
- Sub-module tt_table_ram: 2^N_IN x N_OUT register array with async-reset clear, one write port and one combinational read port. The FSM and output register stay in the top module.

## Test plan
- Reset then query: in_valid=1 with any vector -> in_ready=0, out_valid=0, table_ok=0.
- Load the A-function table (defaults) with words 0000,1001,0000,0110,1100,1001,1100,0110 -> table_ok=1 after the 8th word. Query 3'b011 -> 4'b0110 one cycle later; query 3'b100 -> 4'b1100.
- Back-to-back sweep of 000..111 with out_ready=1 -> 8 consecutive out_valid cycles in order, no bubbles.
- Backpressure: hold out_ready=0 for 3 cycles after query 3'b001 -> out_word=4'b1001 stable, in_ready=0. Release -> drains, and the next query is accepted in the same cycle.
- Reload mid-stream: issue cfg_start with a pending output -> the output still drains. Load all-1111 -> query 3'b000 returns 4'b1111. Issue cfg_start after 3 words -> load restarts at index 0.
- Async rst mid-load at word 5 -> all outputs return to reset values within the same cycle; a fresh load and queries behave as in scenario 2.
